// File: rtl/store_narrow_serializer.sv
// Narrows a 64-bit store value to 1/2/4/8 bytes and writes it little-endian to a byte-wide port.
// Optional truncation flag is enabled by defining TRUNC_FLAG_EN.
module store_narrow_serializer #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        in_size,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              trunc_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] shreg;
  logic [ADDR_W-1:0] base;
  logic [2:0]        idx;
  logic [2:0]        last;
  logic [2:0]        last_nx;
  logic              accept;
  logic              last_byte;

  assign accept    = in_valid & in_ready;
  assign last_byte = (idx == last);

  always_comb begin
    last_nx = 3'd0;
    unique case (1'b1)
      (in_size == 2'b00): last_nx = 3'd0;
      (in_size == 2'b01): last_nx = 3'd1;
      (in_size == 2'b10): last_nx = 3'd3;
      (in_size == 2'b11): last_nx = 3'd7;
      default:            last_nx = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = SEND;
      SEND: if (mem_ready && last_byte) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      base  <= '0;
      idx   <= 3'd0;
      last  <= 3'd0;
    end else if (accept) begin
      shreg <= in_data;
      base  <= in_addr;
      idx   <= 3'd0;
      last  <= last_nx;
    end else if (state == SEND && mem_ready && !last_byte) begin
      shreg <= {8'h00, shreg[DATA_W-1:8]};
      idx   <= idx + 3'd1;
    end
  end

  // Outputs decode from state alone, so reset drops mem_wr_en asynchronously.
  always_comb begin
    in_ready  = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: in_ready = 1'b1;
      SEND: begin
        mem_wr_en = 1'b1;
        mem_addr  = base + ADDR_W'(idx);
        mem_wdata = shreg[7:0];
        busy      = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef TRUNC_FLAG_EN
  logic trunc_q;
  logic trunc_nx;

  always_comb begin
    trunc_nx = 1'b0;
    unique case (1'b1)
      (in_size == 2'b00): trunc_nx = |in_data[63:8];
      (in_size == 2'b01): trunc_nx = |in_data[63:16];
      (in_size == 2'b10): trunc_nx = |in_data[63:32];
      (in_size == 2'b11): trunc_nx = 1'b0;
      default:            trunc_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trunc_q <= 1'b0;
    end else if (accept) begin
      trunc_q <= trunc_nx;
    end
  end

  assign trunc_err = trunc_q;
`else
  assign trunc_err = 1'b0;
`endif

endmodule

// File: tb/tb_store_narrow_serializer.sv
// Directed bench for store_narrow_serializer.
// Expected trunc_err follows TRUNC_FLAG_EN.
module tb_store_narrow_serializer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_addr;
  logic [1:0]  in_size;
  logic        mem_wr_en;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic        trunc_err;

  int tests;
  int fails;

  logic [7:0]  dw_bytes [8];
  logic [63:0] wr_addrs [4];
  logic [7:0]  wr_bytes [4];
  logic        tr_exp;

  store_narrow_serializer #(.DATA_W(64), .ADDR_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_size   (in_size),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .trunc_err (trunc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    dw_bytes = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    wr_addrs = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h0, 64'h1};
    wr_bytes = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
`ifdef TRUNC_FLAG_EN
    tr_exp = 1'b1;
`else
    tr_exp = 1'b0;
`endif
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_addr   = '0;
    in_size   = 2'b00;
    mem_ready = 1'b1;

    // reset state
    #12;
    chk("rst_wr_en", 64'(mem_wr_en), 64'h0);
    chk("rst_addr", mem_addr, 64'h0);
    chk("rst_wdata", 64'(mem_wdata), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_trunc", 64'(trunc_err), 64'h0);
    reset = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // 1: byte store
    in_valid = 1'b1;
    in_data  = 64'h1122_3344_5566_7788;
    in_addr  = 64'h100;
    in_size  = 2'b00;
    step();
    in_valid = 1'b0;
    chk("t1_wr_en", 64'(mem_wr_en), 64'h1);
    chk("t1_addr", mem_addr, 64'h100);
    chk("t1_data", 64'(mem_wdata), 64'h88);
    chk("t1_in_ready_busy", 64'(in_ready), 64'h0);
    chk("t1_busy", 64'(busy), 64'h1);
    step();
    chk("t1_done", 64'(done), 64'h1);
    chk("t1_done_wr_en", 64'(mem_wr_en), 64'h0);
    chk("t1_done_in_ready", 64'(in_ready), 64'h0);
    step();
    chk("t1_done_pulse", 64'(done), 64'h0);
    chk("t1_in_ready_back", 64'(in_ready), 64'h1);
    chk("t1_idle_busy", 64'(busy), 64'h0);

    // 2: dword store, size change after accept ignored
    in_valid = 1'b1;
    in_addr  = 64'h200;
    in_size  = 2'b11;
    step();
    in_valid = 1'b0;
    in_size  = 2'b00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_wr_en%0d", i), 64'(mem_wr_en), 64'h1);
      chk($sformatf("t2_addr%0d", i), mem_addr, 64'h200 + 64'(i));
      chk($sformatf("t2_data%0d", i), 64'(mem_wdata), 64'(dw_bytes[i]));
      chk($sformatf("t2_done_lo%0d", i), 64'(done), 64'h0);
      step();
    end
    chk("t2_done", 64'(done), 64'h1);
    chk("t2_done_wr_en", 64'(mem_wr_en), 64'h0);
    step();

    // 3: back-pressure on a half store
    in_valid  = 1'b1;
    in_data   = 64'h0000_0000_0000_BEEF;
    in_addr   = 64'h40;
    in_size   = 2'b01;
    mem_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_hold_addr%0d", i), mem_addr, 64'h40);
      chk($sformatf("t3_hold_data%0d", i), 64'(mem_wdata), 64'hEF);
      chk($sformatf("t3_hold_wr_en%0d", i), 64'(mem_wr_en), 64'h1);
      if (i == 2) mem_ready = 1'b1;
      step();
    end
    chk("t3_addr1", mem_addr, 64'h41);
    chk("t3_data1", 64'(mem_wdata), 64'hBE);
    chk("t3_no_early_done", 64'(done), 64'h0);
    step();
    chk("t3_done", 64'(done), 64'h1);
    step();
    chk("t3_done_once", 64'(done), 64'h0);

    // 4: word store with address wrap
    in_valid = 1'b1;
    in_data  = 64'h0000_0000_CAFE_F00D;
    in_addr  = 64'hFFFF_FFFF_FFFF_FFFE;
    in_size  = 2'b10;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_addr%0d", i), mem_addr, wr_addrs[i]);
      chk($sformatf("t4_data%0d", i), 64'(mem_wdata), 64'(wr_bytes[i]));
      step();
    end
    chk("t4_done", 64'(done), 64'h1);
    step();

    // 5: reset after three bytes accepted
    in_valid = 1'b1;
    in_data  = 64'h1122_3344_5566_7788;
    in_addr  = 64'h300;
    in_size  = 2'b11;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("t5_fourth_addr", mem_addr, 64'h303);
    chk("t5_fourth_data", 64'(mem_wdata), 64'h55);
    reset = 1'b0;
    #1;
    chk("t5_async_wr_en", 64'(mem_wr_en), 64'h0);
    chk("t5_async_busy", 64'(busy), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t5_no_wr%0d", i), 64'(mem_wr_en), 64'h0);
    end
    reset = 1'b1;
    step();
    chk("t5_in_ready", 64'(in_ready), 64'h1);
    chk("t5_idle_wr_en", 64'(mem_wr_en), 64'h0);
    chk("t5_idle_addr", mem_addr, 64'h0);

    // 6: truncation flag
    in_valid = 1'b1;
    in_data  = 64'h0000_0000_0000_0100;
    in_addr  = 64'h500;
    in_size  = 2'b00;
    step();
    in_valid = 1'b0;
    chk("t6_byte_data", 64'(mem_wdata), 64'h00);
    chk("t6_trunc_byte", 64'(trunc_err), 64'(tr_exp));
    step();
    step();
    chk("t6_trunc_hold", 64'(trunc_err), 64'(tr_exp));
    in_valid = 1'b1;
    in_data  = 64'h0000_0000_FFFF_FFFF;
    in_size  = 2'b10;
    step();
    in_valid = 1'b0;
    chk("t6_trunc_word", 64'(trunc_err), 64'h0);
    chk("t6_word_data0", 64'(mem_wdata), 64'hFF);
    for (int i = 0; i < 5; i++) step();
    chk("t6_back_idle", 64'(in_ready), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_narrow_serializer.md
Name: store_narrow_serializer

Overview:
Store-side counterpart of the immediate zero-extender. It takes a 64-bit register value plus a size code and narrows it to 1, 2, 4 or 8 bytes. It then serializes those bytes little-endian onto the byte-wide data-memory write port, one byte per accepted memory cycle. It sits between the MEM stage store path (STUR/STURW/STURH/STURB) and the byte-wide data memory. Flow control is valid/ready upstream and ready-gated downstream.

Parameters:
DATA_W, 64, width of the store data input; must be 64.
ADDR_W, 64, width of the byte address.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  store request present.
in_ready  output  1  block can accept a request (high only in IDLE).
in_data  input  DATA_W  register value to store.
in_addr  input  ADDR_W  byte address of the least significant byte.
in_size  input  2  00=byte, 01=half, 10=word, 11=dword.
mem_wr_en  output  1  byte write request to memory.
mem_addr  output  ADDR_W  byte address of the current write.
mem_wdata  output  8  byte being written.
mem_ready  input  1  memory accepts the current byte this cycle.
busy  output  1  high in SEND or DONE.
done  output  1  one-cycle pulse when the last byte has been accepted.
trunc_err  output  1  truncation flag (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; mem_wr_en=0, mem_addr=0, mem_wdata=0, busy=0, done=0, trunc_err=0, in_ready=1 once reset releases. Internal shift register, base address and byte index clear to 0.
- States: IDLE, SEND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge N: latch in_data into shift register and in_addr into base.
  - Set last = (1<<in_size)-1, index = 0, go to SEND.
- SEND:
  - mem_wr_en=1; mem_wdata = shreg[7:0]; mem_addr = base + index. Address addition wraps modulo 2^ADDR_W.
  - On mem_ready=1: shift shreg right 8 bits and increment index. If index==last, go to DONE instead.
  - On mem_ready=0: all outputs are held stable; no shift, no increment.
- DONE:
  - done=1 and mem_wr_en=0 for exactly one cycle, then IDLE.
  - in_ready=0 in DONE, so there is no same-cycle re-accept.
- Latency: accept at edge N gives the first byte on the bus in cycle N+1. With mem_ready held high, done is asserted in cycle N+1+B, where B = bytes (1/2/4/8). The next request is accepted at the earliest at edge N+2+B.
- Bytes above the selected size are discarded and never driven to memory.
- in_valid while busy: ignored; the requester must hold it until in_ready is seen.
- Reset mid-SEND: the transfer aborts immediately, mem_wr_en drops asynchronously, and no remaining bytes are written.
- in_size is sampled only at accept; later changes have no effect.
- mem_wr_en is never high in IDLE or DONE.

Optional Feature:
TRUNC_FLAG_EN
- Defined:
  - At accept, trunc_err is registered to 1 if any in_data bit above the selected width is nonzero. The checked bits are [63:8] for byte, [63:16] for half, [63:32] for word; dword always gives 0.
  - The flag holds until the next accept or reset.
  - Informational only: the transfer proceeds unchanged.
- Not defined: trunc_err is tied to 0 and the check logic is absent.

Test Plan:
1. Byte store: in_data=64'h1122334455667788, in_addr=64'h100, in_size=00, mem_ready=1. Expect one write (addr 0x100, data 0x88), done in cycle N+2, in_ready back high in cycle N+3.
2. Dword store: same data, in_addr=64'h200, size=11, mem_ready=1. Expect 8 writes at 0x200..0x207 with bytes 88,77,66,55,44,33,22,11 in order, and done in cycle N+9.
3. Back-pressure: half store of 16'hBEEF at 0x40 with mem_ready low for 3 cycles in SEND. mem_addr=0x40 and mem_wdata=0xEF held for all 3 cycles, then 0x41/0xBE; done exactly once.
4. Wrap-around: word store of 32'hCAFEF00D at in_addr=64'hFFFFFFFFFFFFFFFE. Writes go to addresses ...FE, ...FF, 0x0, 0x1 with bytes 0D, F0, FE, CA.
5. Reset mid-op: dword store, assert reset after 3 bytes are accepted. mem_wr_en=0 immediately, no further writes, and after release state=IDLE with in_ready=1.
6. TRUNC_FLAG_EN: byte store of 64'h0000000000000100 sets trunc_err=1. A following word store of 64'h00000000FFFFFFFF sets trunc_err=0. With the macro undefined, trunc_err=0 in both cases.
